// File: rtl/artyz7_led_fanout_pkg.sv
// Shared constants, offset type and modulo index helper for the Arty Z7 LED fan-out block.
// The optional edge-pulse path is controlled by ARTYZ7_LED_FANOUT_EDGE_PULSE_EN.
package artyz7_led_fanout_pkg;

    localparam int NUM_LEDS                = 4;
    localparam int NUM_DUMMY_OUTPUT        = 23;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;
    localparam int DEFAULT_ROTATE_PERIOD   = 50000000;
    localparam int DEFAULT_OFFSET_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    typedef logic [DEFAULT_OFFSET_W-1:0] offset_t;

    // Channel feeding output bit bit_idx when the mapping is rotated by off.
    function automatic int unsigned fanout_index(input int unsigned bit_idx,
                                                 input int unsigned off,
                                                 input int unsigned num_ch);
        return (bit_idx + off) % num_ch;
    endfunction

endpackage

// File: rtl/artyz7_debounce_channel.sv
// One input channel: multi-flop synchroniser followed by a mismatch-counting debouncer.
// The rise output is only generated when ARTYZ7_LED_FANOUT_EDGE_PULSE_EN is defined.
module artyz7_debounce_channel
    import artyz7_led_fanout_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_bit;

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din};
        sync_bit = sync_q[SYNC_STAGES-1];
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_bit == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_bit;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

`ifdef ARTYZ7_LED_FANOUT_EDGE_PULSE_EN
    logic prev_q, prev_d;

    always_comb begin
        prev_d = stable_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = stable_q & ~prev_q;
`else
    assign rise = 1'b0;
`endif

endmodule

// File: rtl/artyz7_led_fanout_debounce.sv
// Debounced LED inputs fanned out to NUM_OUTPUTS pins through a periodically rotating mapping.
// Define ARTYZ7_LED_FANOUT_EDGE_PULSE_EN to enable the edge_pulse outputs (tied low otherwise).
module artyz7_led_fanout_debounce
    import artyz7_led_fanout_pkg::*;
#(
    parameter int NUM_INPUTS      = NUM_LEDS,
    parameter int NUM_OUTPUTS     = NUM_DUMMY_OUTPUT,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ROTATE_PERIOD   = DEFAULT_ROTATE_PERIOD,
    localparam int OFF_W          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                   ext_clk,
    input  logic                   reset,
    input  logic [NUM_INPUTS-1:0]  led,
    input  logic                   rotate_enable,
    output logic [NUM_INPUTS-1:0]  stable_led,
    output logic [NUM_INPUTS-1:0]  edge_pulse,
    output logic [NUM_OUTPUTS-1:0] dummy_output,
    output logic [OFF_W-1:0]       offset
);

    localparam int RC_W  = (ROTATE_PERIOD > 1) ? $clog2(ROTATE_PERIOD) : 1;
    localparam int IDX_W = $clog2(NUM_OUTPUTS + NUM_INPUTS) + 1;
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(ROTATE_PERIOD - 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(NUM_INPUTS - 1);

    logic [NUM_INPUTS-1:0]  stable, rise;
    logic [RC_W-1:0]        rot_cnt_q, rot_cnt_d;
    logic [OFF_W-1:0]       offset_q, offset_d;
    logic [NUM_OUTPUTS-1:0] dummy_q, dummy_d;
    logic [IDX_W-1:0]       sel;

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_ch
        artyz7_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (ext_clk),
            .reset  (reset),
            .din    (led[k]),
            .stable (stable[k]),
            .rise   (rise[k])
        );
    end

    // Disabling rotation pauses both the period counter and the offset.
    always_comb begin
        rot_cnt_d = rot_cnt_q;
        offset_d  = offset_q;
        if (rotate_enable) begin
            if (rot_cnt_q == RC_LAST) begin
                rot_cnt_d = '0;
                offset_d  = (offset_q == OFF_LAST) ? '0 : offset_q + OFF_W'(1);
            end else begin
                rot_cnt_d = rot_cnt_q + RC_W'(1);
            end
        end
    end

    always_comb begin
        dummy_d = '0;
        sel     = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            sel = IDX_W'(fanout_index(i, 32'(offset_q), NUM_INPUTS));
            for (int k = 0; k < NUM_INPUTS; k++) begin
                if (sel == IDX_W'(k)) begin
                    dummy_d[i] = stable[k];
                end
            end
        end
    end

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            rot_cnt_q <= '0;
            offset_q  <= '0;
            dummy_q   <= '0;
        end else begin
            rot_cnt_q <= rot_cnt_d;
            offset_q  <= offset_d;
            dummy_q   <= dummy_d;
        end
    end

    assign stable_led   = stable;
    assign edge_pulse   = rise;
    assign dummy_output = dummy_q;
    assign offset       = offset_q;

endmodule

// File: tb/tb_artyz7_led_fanout_debounce.sv
// Bench for artyz7_led_fanout_debounce: directed scenarios plus randomized run against a reference model.
module tb_artyz7_led_fanout_debounce;

    localparam int NI = 4;
    localparam int NO = 23;
    localparam int SS = 2;
    localparam int DC = 8;
    localparam int RP = 16;
`ifdef ARTYZ7_LED_FANOUT_EDGE_PULSE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    logic          ext_clk = 1'b0;
    logic          reset;
    logic [NI-1:0] led;
    logic          rotate_enable;
    logic [NI-1:0] stable_led;
    logic [NI-1:0] edge_pulse;
    logic [NO-1:0] dummy_output;
    logic [1:0]    offset;

    int checks = 0;
    int errors = 0;

    always #5 ext_clk = ~ext_clk;

    artyz7_led_fanout_debounce #(
        .NUM_INPUTS      (NI),
        .NUM_OUTPUTS     (NO),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .ROTATE_PERIOD   (RP)
    ) dut (
        .ext_clk       (ext_clk),
        .reset         (reset),
        .led           (led),
        .rotate_enable (rotate_enable),
        .stable_led    (stable_led),
        .edge_pulse    (edge_pulse),
        .dummy_output  (dummy_output),
        .offset        (offset)
    );

    // Reference model: sync = input delayed SS samples, level accepted after DC
    // consecutive disagreeing samples, offset = (enabled cycles / RP) mod NI.
    logic [NI-1:0] m_stable, m_prev;
    logic [NO-1:0] m_dummy;
    int            m_run[NI];
    logic [NI-1:0] m_pipe[$];
    int            m_en;
    int            m_off;

    task automatic model_step(input logic [NI-1:0] l, input logic re, input logic rs);
        logic [NI-1:0] s;
        logic [NO-1:0] nd;
        if (rs) begin
            m_stable = '0;
            m_prev   = '0;
            m_dummy  = '0;
            for (int k = 0; k < NI; k++) m_run[k] = 0;
            m_pipe.delete();
            for (int k = 0; k < SS; k++) m_pipe.push_back('0);
            m_en  = 0;
            m_off = 0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(l);
            for (int i = 0; i < NO; i++) nd[i] = m_stable[(i + m_off) % NI];
            m_prev = m_stable;
            for (int k = 0; k < NI; k++) begin
                if (s[k] !== m_prev[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DC) begin
                        m_stable[k] = s[k];
                        m_run[k]    = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_dummy = nd;
            if (re) begin
                m_en++;
                m_off = (m_en / RP) % NI;
            end
        end
    endtask

    task automatic cycle(input logic [NI-1:0] l, input logic re, input logic rs);
        led           = l;
        rotate_enable = re;
        reset         = rs;
        @(posedge ext_clk);
        model_step(l, re, rs);
        #1;
    endtask

    task automatic test_reset();
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        checks++; if (stable_led !== 4'b0) begin errors++; $display("FAIL reset_stable: got %b expected 0000", stable_led); end
        checks++; if (edge_pulse !== 4'b0) begin errors++; $display("FAIL reset_edge: got %b expected 0000", edge_pulse); end
        checks++; if (dummy_output !== 23'h0) begin errors++; $display("FAIL reset_dummy: got %h expected 000000", dummy_output); end
        checks++; if (offset !== 2'd0) begin errors++; $display("FAIL reset_offset: got %0d expected 0", offset); end
        cycle(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_debounce_accept();
        int accept_at = -1;
        int edge_cnt  = 0;
        for (int n = 1; n <= 14; n++) begin
            cycle(4'b0001, 1'b0, 1'b0);
            if (accept_at < 0 && stable_led[0] === 1'b1) accept_at = n;
            if (edge_pulse !== 4'b0) edge_cnt++;
            if (n == accept_at) begin
                checks++; if (edge_pulse[0] !== EDGE_EN) begin errors++; $display("FAIL accept_edge: got %b expected %b", edge_pulse[0], EDGE_EN); end
            end
            if (n == accept_at + 1) begin
                checks++; if (dummy_output !== 23'h111111) begin errors++; $display("FAIL accept_dummy: got %h expected 111111", dummy_output); end
                checks++; if (edge_pulse !== 4'b0) begin errors++; $display("FAIL accept_edge_one_cycle: got %b expected 0000", edge_pulse); end
            end
        end
        checks++; if (accept_at !== 10) begin errors++; $display("FAIL accept_latency: got %0d expected 10", accept_at); end
        checks++; if (edge_cnt !== (EDGE_EN ? 1 : 0)) begin errors++; $display("FAIL accept_edge_count: got %0d expected %0d", edge_cnt, EDGE_EN ? 1 : 0); end
        checks++; if (stable_led !== 4'b0001) begin errors++; $display("FAIL accept_stable: got %b expected 0001", stable_led); end
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        int   accept_at = -1;
        logic acc_edge = 1'b0;
        for (int n = 0; n < 7; n++) begin
            cycle(4'b0011, 1'b0, 1'b0);
            seen |= stable_led[1] | edge_pulse[1];
        end
        for (int n = 0; n < 15; n++) begin
            cycle(4'b0001, 1'b0, 1'b0);
            seen |= stable_led[1] | edge_pulse[1];
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch7_rejected: got %b expected 0", seen); end
        for (int n = 0; n < 4; n++) cycle(4'b0011, 1'b0, 1'b0);
        cycle(4'b0001, 1'b0, 1'b0);
        seen = stable_led[1];
        for (int n = 1; n <= 13; n++) begin
            cycle(4'b0011, 1'b0, 1'b0);
            if (accept_at < 0 && stable_led[1] === 1'b1) begin
                accept_at = n;
                acc_edge  = edge_pulse[1];
            end
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch4_rejected: got %b expected 0", seen); end
        checks++; if (accept_at !== 10) begin errors++; $display("FAIL restart_latency: got %0d expected 10", accept_at); end
        checks++; if (acc_edge !== EDGE_EN) begin errors++; $display("FAIL restart_edge: got %b expected %b", acc_edge, EDGE_EN); end
    endtask

    task automatic settle_one();
        cycle(4'b0000, 1'b0, 1'b1);
        for (int n = 0; n < 12; n++) cycle(4'b0001, 1'b0, 1'b0);
    endtask

    task automatic test_rotation();
        settle_one();
        for (int n = 1; n <= 64; n++) begin
            cycle(4'b0001, 1'b1, 1'b0);
            if (n == 15 || n == 16 || n == 32 || n == 47 || n == 48 || n == 64) begin
                checks++;
                if (offset !== 2'((n / RP) % NI)) begin errors++; $display("FAIL rotate_offset_n%0d: got %0d expected %0d", n, offset, (n / RP) % NI); end
            end
            if (n == 17) begin
                checks++; if (dummy_output !== 23'h088888) begin errors++; $display("FAIL rotate_dummy: got %h expected 088888", dummy_output); end
            end
        end
    endtask

    task automatic test_pause();
        settle_one();
        for (int n = 0; n < 10; n++) cycle(4'b0001, 1'b1, 1'b0);
        for (int n = 0; n < 20; n++) cycle(4'b0001, 1'b0, 1'b0);
        checks++; if (offset !== 2'd0) begin errors++; $display("FAIL pause_hold: got %0d expected 0", offset); end
        for (int n = 0; n < 5; n++) cycle(4'b0001, 1'b1, 1'b0);
        checks++; if (offset !== 2'd0) begin errors++; $display("FAIL pause_resume_early: got %0d expected 0", offset); end
        cycle(4'b0001, 1'b1, 1'b0);
        checks++; if (offset !== 2'd1) begin errors++; $display("FAIL pause_resume_step: got %0d expected 1", offset); end
    endtask

    task automatic test_reset_mid();
        int accept_at = -1;
        int early_edges = 0;
        settle_one();
        for (int n = 0; n < 32; n++) cycle(4'b0001, 1'b1, 1'b0);
        checks++; if (offset !== 2'd2) begin errors++; $display("FAIL midreset_pre_offset: got %0d expected 2", offset); end
        for (int n = 0; n < 6; n++) cycle(4'b0011, 1'b1, 1'b0);
        cycle(4'b0011, 1'b1, 1'b1);
        checks++; if ({stable_led, edge_pulse, dummy_output, offset} !== '0) begin
            errors++; $display("FAIL midreset_clear: got stable=%b edge=%b dummy=%h offset=%0d expected all 0", stable_led, edge_pulse, dummy_output, offset);
        end
        for (int n = 1; n <= 12; n++) begin
            cycle(4'b0011, 1'b0, 1'b0);
            if (accept_at < 0 && stable_led === 4'b0011) accept_at = n;
            if (accept_at < 0 && edge_pulse !== 4'b0) early_edges++;
        end
        checks++; if (accept_at !== 10) begin errors++; $display("FAIL midreset_restart: got %0d expected 10", accept_at); end
        checks++; if (early_edges !== 0) begin errors++; $display("FAIL midreset_no_pulse: got %0d expected 0", early_edges); end
        checks++; if (offset !== 2'd0) begin errors++; $display("FAIL midreset_offset: got %0d expected 0", offset); end
    endtask

    task automatic test_random();
        logic [NI-1:0] l = '0;
        logic          re = 1'b0;
        logic          rs;
        int            hold = 0;
        logic [NI-1:0] exp_edge;
        cycle(4'b0000, 1'b0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                l    = NI'($urandom);
                hold = ($urandom_range(0, 2) == 0) ? $urandom_range(DC, 3 * DC) : $urandom_range(1, DC + 1);
            end
            hold--;
            if ($urandom_range(0, 39) == 0) re = ~re;
            rs = ($urandom_range(0, 499) == 0);
            cycle(l, re, rs);
            exp_edge = EDGE_EN ? (m_stable & ~m_prev) : '0;
            checks++; if (stable_led !== m_stable) begin errors++; $display("FAIL rand_stable c%0d: got %b expected %b", n, stable_led, m_stable); end
            checks++; if (edge_pulse !== exp_edge) begin errors++; $display("FAIL rand_edge c%0d: got %b expected %b", n, edge_pulse, exp_edge); end
            checks++; if (dummy_output !== m_dummy) begin errors++; $display("FAIL rand_dummy c%0d: got %h expected %h", n, dummy_output, m_dummy); end
            checks++; if (offset !== 2'(m_off)) begin errors++; $display("FAIL rand_offset c%0d: got %0d expected %0d", n, offset, m_off); end
        end
    endtask

    initial begin
        reset         = 1'b1;
        led           = '0;
        rotate_enable = 1'b0;
        test_reset();
        test_debounce_accept();
        test_glitch();
        test_rotation();
        test_pause();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
